// File: rtl/fp32_pkg.sv
// Shared binary32 type, constants and operand-classification helpers
// for the floating-point calculator datapath.
package fp32_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  localparam logic [7:0]  BIAS    = 8'd127;
  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam logic [31:0] NEG_INF = 32'hFF800000;

  // Quiet or signalling NaN.
  function automatic logic fp_is_nan(input fp32_t x);
    return (x.exp == EXP_MAX) && (x.man != 23'd0);
  endfunction

  // Signed infinity.
  function automatic logic fp_is_inf(input fp32_t x);
    return (x.exp == EXP_MAX) && (x.man == 23'd0);
  endfunction

  // Zero or denormal; denormals are treated as zero on input.
  function automatic logic fp_is_zero(input fp32_t x);
    return (x.exp == 8'd0);
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// 27-bit leading-zero counter used to normalise the significand after an
// effective subtraction. An all-zero input reports 27.
module fp_lzc
  import fp32_pkg::*;
(
  input  logic [26:0] in_i,
  output logic [4:0]  count_o
);

  // Scan from LSB to MSB so the highest set bit determines the count.
  always_comb begin
    count_o = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (in_i[i]) begin
        count_o = 5'(26 - i);
      end else begin
        count_o = count_o;
      end
    end
  end

endmodule

// File: rtl/fp32_add_sub.sv
// Single-precision adder/subtractor with DAZ/FTZ, round-to-nearest-even,
// overflow/underflow flags and a single registered output stage.
module fp32_add_sub
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        checkequation,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);

  fp32_t        a_s, b_s;
  fp32_t        big_s, small_s;
  logic [7:0]   exp_diff_s;
  logic [26:0]  small_ext_s, shifted_s, lost_mask_s, aligned_s;
  logic [27:0]  sum_s;
  logic         eff_sub_s;
  logic [4:0]   lz_s;
  logic [26:0]  norm_s;
  logic signed [9:0] exp_norm_s, exp_fin_s;
  logic         round_up_s;
  logic [24:0]  mant_rnd_s;

  logic [31:0]  result_d, result_q;
  logic         overflow_d, overflow_q;
  logic         underflow_d, underflow_q;

  // Subtraction is addition with B's sign inverted.
  assign a_s = A;
  assign b_s = {B[31] ^ checkequation, B[30:0]};

  // Order operands by magnitude so the larger one sets sign and exponent.
  always_comb begin
    if (a_s[30:0] >= b_s[30:0]) begin
      big_s   = a_s;
      small_s = b_s;
    end else begin
      big_s   = b_s;
      small_s = a_s;
    end
  end

  assign eff_sub_s  = a_s.sign ^ b_s.sign;
  assign exp_diff_s = big_s.exp - small_s.exp;

  // Align the smaller significand, folding shifted-out bits into sticky.
  always_comb begin
    small_ext_s = {1'b1, small_s.man, 3'b000};
    shifted_s   = 27'd0;
    lost_mask_s = 27'd0;
    if (exp_diff_s >= 8'd26) begin
      aligned_s = 27'd1;
    end else begin
      shifted_s   = small_ext_s >> exp_diff_s[4:0];
      lost_mask_s = (27'd1 << exp_diff_s[4:0]) - 27'd1;
      aligned_s   = {shifted_s[26:1],
                     shifted_s[0] | ((small_ext_s & lost_mask_s) != 27'd0)};
    end
  end

  // Significand add/subtract with one bit of carry headroom.
  always_comb begin
    if (eff_sub_s) begin
      sum_s = {1'b0, 1'b1, big_s.man, 3'b000} - {1'b0, aligned_s};
    end else begin
      sum_s = {1'b0, 1'b1, big_s.man, 3'b000} + {1'b0, aligned_s};
    end
  end

  fp_lzc u_lzc (
    .in_i    (sum_s[26:0]),
    .count_o (lz_s)
  );

  // Normalise: right by one on carry-out, otherwise left by the leading-zero count.
  always_comb begin
    if (sum_s[27]) begin
      norm_s     = {sum_s[27:2], sum_s[1] | sum_s[0]};
      exp_norm_s = $signed({2'b00, big_s.exp}) + 10'sd1;
    end else begin
      norm_s     = sum_s[26:0] << lz_s;
      exp_norm_s = $signed({2'b00, big_s.exp}) - $signed({5'b00000, lz_s});
    end
  end

  // Round to nearest, ties to even; a carry out of rounding bumps the exponent.
  always_comb begin
    round_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
    mant_rnd_s = {1'b0, norm_s[26:3]} + {24'd0, round_up_s};
    if (mant_rnd_s[24]) begin
      exp_fin_s = exp_norm_s + 10'sd1;
    end else begin
      exp_fin_s = exp_norm_s;
    end
  end

  // Special-case priority mux and range checks on the finite result.
  always_comb begin
    result_d    = 32'd0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (fp_is_nan(a_s) || fp_is_nan(b_s)) begin
      result_d = QNAN;
    end else if (fp_is_inf(a_s) && fp_is_inf(b_s)) begin
      if (eff_sub_s) begin
        result_d = QNAN;
      end else begin
        result_d = a_s;
      end
    end else if (fp_is_inf(a_s)) begin
      result_d = a_s;
    end else if (fp_is_inf(b_s)) begin
      result_d = b_s;
    end else if (fp_is_zero(a_s) && fp_is_zero(b_s)) begin
      result_d = {a_s.sign & b_s.sign, 31'd0};
    end else if (fp_is_zero(a_s)) begin
      result_d = b_s;
    end else if (fp_is_zero(b_s)) begin
      result_d = a_s;
    end else if (sum_s == 28'd0) begin
      result_d = 32'd0;
    end else if (exp_fin_s > 10'sd254) begin
      result_d   = big_s.sign ? NEG_INF : POS_INF;
      overflow_d = 1'b1;
    end else if (exp_fin_s < 10'sd1) begin
      result_d    = {big_s.sign, 31'd0};
      underflow_d = 1'b1;
    end else begin
      result_d = {big_s.sign, exp_fin_s[7:0],
                  mant_rnd_s[24] ? 23'd0 : mant_rnd_s[22:0]};
    end
  end

  // Single output register stage; asynchronous reset clears result and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q    <= 32'd0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign result    = result_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fp32_add_sub.sv
// Directed self-checking bench for fp32_add_sub with hand-computed vectors.
module tb_fp32_add_sub;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic        checkequation;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  int checks;
  int failures;

  fp32_add_sub dut (
    .clk           (clk),
    .rst           (rst),
    .A             (A),
    .B             (B),
    .checkequation (checkequation),
    .result        (result),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] exp_res,
                       input logic exp_ov, input logic exp_uf);
    checks++;
    assert ({result, overflow, underflow} === {exp_res, exp_ov, exp_uf})
    else begin
      failures++;
      $error("FAIL %s: observed result=%08h ov=%0b uf=%0b expected result=%08h ov=%0b uf=%0b",
             tag, result, overflow, underflow, exp_res, exp_ov, exp_uf);
    end
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic op);
    @(negedge clk);
    A = a;
    B = b;
    checkequation = op;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    A = 32'h3F800000;
    B = 32'h3F800000;
    checkequation = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_state", 32'h00000000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    apply(32'h3F800000, 32'h40000000, 1'b1); check("1_minus_2",     32'hBF800000, 1'b0, 1'b0);
    apply(32'h3F800000, 32'h3F800000, 1'b0); check("1_plus_1",      32'h40000000, 1'b0, 1'b0);
    @(posedge clk); #1;                      check("hold",          32'h40000000, 1'b0, 1'b0);
    apply(32'h3FC00000, 32'h3FC00000, 1'b0); check("1p5_plus_1p5",  32'h40400000, 1'b0, 1'b0);
    apply(32'h3F800000, 32'h33800000, 1'b0); check("tie_even_down", 32'h3F800000, 1'b0, 1'b0);
    apply(32'h3F800001, 32'h33800000, 1'b0); check("tie_even_up",   32'h3F800002, 1'b0, 1'b0);
    apply(32'h3F800000, 32'h33800001, 1'b0); check("above_half",    32'h3F800001, 1'b0, 1'b0);
    apply(32'h3F800000, 32'h00800000, 1'b0); check("far_sticky",    32'h3F800000, 1'b0, 1'b0);
    apply(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0); check("overflow",      32'h7F800000, 1'b1, 1'b0);
    apply(32'hFF7FFFFF, 32'h7F7FFFFF, 1'b1); check("neg_overflow",  32'hFF800000, 1'b1, 1'b0);
    apply(32'h00000000, 32'h00000000, 1'b1); check("zero_m_zero",   32'h00000000, 1'b0, 1'b0);
    apply(32'h80000000, 32'h00000000, 1'b1); check("nzero_m_zero",  32'h80000000, 1'b0, 1'b0);
    apply(32'h80000000, 32'h00000000, 1'b0); check("mixed_zeros",   32'h00000000, 1'b0, 1'b0);
    apply(32'h00000000, 32'h40400000, 1'b1); check("zero_m_x",      32'hC0400000, 1'b0, 1'b0);
    apply(32'h00000001, 32'h3F800000, 1'b0); check("daz_input",     32'h3F800000, 1'b0, 1'b0);
    apply(32'h7F800000, 32'h00000000, 1'b1); check("inf_m_zero",    32'h7F800000, 1'b0, 1'b0);
    apply(32'h00000000, 32'h7F800000, 1'b1); check("zero_m_inf",    32'hFF800000, 1'b0, 1'b0);
    apply(32'h7F800000, 32'h7F800000, 1'b1); check("inf_m_inf",     32'h7FC00000, 1'b0, 1'b0);
    apply(32'h7F800000, 32'h7F800000, 1'b0); check("inf_p_inf",     32'h7F800000, 1'b0, 1'b0);
    apply(32'h404CAC08, 32'hFFFFFFFF, 1'b1); check("nan_input",     32'h7FC00000, 1'b0, 1'b0);
    apply(32'h00800001, 32'h00800000, 1'b1); check("underflow",     32'h00000000, 1'b0, 1'b1);
    apply(32'h40400000, 32'h40400000, 1'b1); check("cancel",        32'h00000000, 1'b0, 1'b0);

    // Asynchronous reset mid-stream, away from any clock edge.
    apply(32'h3F800000, 32'h40000000, 1'b0); check("pre_reset",     32'h40400000, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 32'h00000000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    apply(32'h3F800000, 32'h40000000, 1'b1); check("after_reset",   32'hBF800000, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
